pwm_peripheral: RTL and testbench
=================================

// Module: pwm_peripheral
// PURPOSE
//  Consumes the five control registers written over SPI (output enables, PWM enables, duty cycle).
//  Drives the 16 user outputs.
//  - Each output is forced low, held high, or driven by a common 8-bit PWM waveform.
//  - Waveform: free-running prescaler plus an 8-bit period counter.
//  - Duty changes are shadowed and applied only at a period boundary, so no runt pulses occur.
//  Sits directly downstream of the SPI register block; outputs go straight to the IO pads.
// PARAMETERS
//  PRESCALE  13  clk cycles per PWM tick (>=1); PWM freq = f_clk/(PRESCALE*256), ~3.0 kHz at 10 MHz
// PORTS
//  clk              in   1  system clock
//  rst              in   1  reset, asynchronous, active-high
//  en_reg_out_7_0   in   8  output enable, bits 7:0 (1 = output may go high)
//  en_reg_out_15_8  in   8  output enable, bits 15:8
//  en_reg_pwm_7_0   in   8  PWM select, bits 7:0 (1 = PWM waveform, 0 = static high)
//  en_reg_pwm_15_8  in   8  PWM select, bits 15:8
//  pwm_duty_cycle   in   8  duty value, 0x00 = 0 %, 0xFF = 100 %
//  out              out 16  registered output drive
//  period_start     out  1  one-clk pulse in the cycle pwm_cnt wraps 255 -> 0
// BEHAVIOUR
//  Reset (async, rst=1): clears prescaler, pwm_cnt, duty_shadow, out and period_start to 0.
//  Prescaler:
//   - pre_cnt counts 0..PRESCALE-1 and then wraps to 0.
//   - tick=1 in the cycle pre_cnt==PRESCALE-1.
//   - PRESCALE=1: tick every cycle.
//   - pre_cnt width is $clog2(PRESCALE), minimum 1.
//  Period counter:
//   - pwm_cnt[7:0] increments on tick and wraps 255 -> 0 (256 ticks per period).
//   - Holds between ticks.
//  Period boundary: tick && pwm_cnt==255. On that clk edge:
//   - pwm_cnt -> 0;
//   - duty_shadow <= pwm_duty_cycle;
//   - period_start <= 1 for exactly one cycle.
//  First period after reset: duty_shadow=0, so PWM channels stay low until the first boundary.
//  Duty changes mid-period are ignored until the next boundary; only the last value before it is taken.
//  pwm_level (combinational, from registered state):
//   - duty_shadow==0xFF -> 1 (true 100 %, no low tick);
//   - otherwise -> (pwm_cnt < duty_shadow), unsigned 8-bit compare;
//   - so duty N (0..254) gives N high ticks and 256-N low ticks per period.
//  Per bit i (en_out/en_pwm are the concatenated 16-bit enable vectors, 15_8 as bits 15:8):
//   - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_level : 1'b1) : 1'b0;
//   - en_out=0 dominates regardless of en_pwm.
//  Enable inputs are NOT shadowed: a change is visible on out one clk later (1-cycle latency).
//  Counter state to out, and duty_shadow to out, also has 1-cycle latency.
//  PWM phase is the same on all channels; every pwm-enabled output switches in the same cycle.
//  Inputs are assumed synchronous to clk (the SPI block updates them on clk); no extra sync here.
//  A mid-period reset restarts at pwm_cnt=0 with duty_shadow=0; the first boundary after release
//  is 256*PRESCALE clks later.
// TESTING
//  - Reset: hold rst with all inputs 0xFF -> out=0x0000, period_start=0 during and 1 clk after release.
//  - Static enables: en_out=0x00FF, en_pwm=0x0000 -> out=0x00FF one clk after the inputs settle;
//    then en_out=0 -> out=0 next clk.
//  - Duty 0x80, PRESCALE=13, en_out=en_pwm=0xFFFF:
//    - after the first period_start, out=0xFFFF for 128*13=1664 clks, then 0x0000 for 1664 clks;
//    - period_start pulses every 3328 clks.
//  - Duty extremes: 0x00 -> out stays 0x0000 over 2 full periods; 0xFF -> out stays 0xFFFF
//    (never drops) over 2 full periods.
//  - Shadowing: duty 0x40 running, write 0x C0 at pwm_cnt=0x10 -> current period still 64 high ticks;
//    next period (after period_start) has 192 high ticks, with no glitch at the switch.
//  - Mixed and mid-op reset: en_out=0xF0F0, en_pwm=0x3333, duty 0x20:
//    - bits 4,5,12,13 PWM; bits 6,7,14,15 high; bits 0-3 and 8-11 low;
//    - assert rst mid-period -> all 0 immediately; counters restart from 0 after release.

Source files
------------

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-channel PWM output stage with shadowed duty cycle
// One common 8-bit PWM waveform; each output is forced low, held high or driven by it.
module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       duty_shadow_q, duty_shadow_d;
  logic [15:0]      out_q, out_d;
  logic             period_start_q, period_start_d;

  logic        tick;
  logic        boundary;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  always_comb begin
    en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    tick     = (pre_cnt_q == PRE_MAX);
    boundary = tick && (pwm_cnt_q == 8'hFF);

    pre_cnt_d      = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    // Duty is only sampled at the wrap so a period never mixes two duty values.
    duty_shadow_d  = boundary ? pwm_duty_cycle : duty_shadow_q;
    period_start_d = boundary;

    // 0xFF is a true 100 %: the compare alone would leave one low tick.
    pwm_level = (duty_shadow_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_shadow_q);
    out_d     = en_out & (~en_pwm | {16{pwm_level}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= 8'd0;
      duty_shadow_q  <= 8'd0;
      out_q          <= 16'd0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - self-checking bench for pwm_peripheral
// Reference derives counter state from the number of clocks since reset release.
module tb_pwm_peripheral;

  localparam int          P   = 13;
  localparam int unsigned PU  = 13;
  localparam int unsigned PER = 256 * PU;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  en_reg_out_7_0  = 8'hFF;
  logic [7:0]  en_reg_out_15_8 = 8'hFF;
  logic [7:0]  en_reg_pwm_7_0  = 8'hFF;
  logic [7:0]  en_reg_pwm_15_8 = 8'hFF;
  logic [7:0]  pwm_duty_cycle  = 8'hFF;
  logic [15:0] out;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  // Reference model: position in period = clocks since release modulo 256*P.
  int unsigned cyc;
  logic [7:0]  m_shadow;
  logic [15:0] exp_out;
  logic        exp_ps;
  logic [7:0]  m_cnt;
  logic        m_bnd;
  logic        m_lvl;

  assign m_cnt = 8'((cyc / PU) % 256);
  assign m_bnd = ((cyc % PER) == (PER - 1));
  assign m_lvl = (m_shadow == 8'hFF) || (m_cnt < m_shadow);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc      <= 0;
      m_shadow <= 8'd0;
      exp_out  <= 16'd0;
      exp_ps   <= 1'b0;
    end else begin
      exp_out  <= {en_reg_out_15_8, en_reg_out_7_0} &
                  (~{en_reg_pwm_15_8, en_reg_pwm_7_0} | {16{m_lvl}});
      exp_ps   <= m_bnd;
      if (m_bnd) m_shadow <= pwm_duty_cycle;
      cyc      <= cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    chk("out", out, exp_out);
    chk("period_start", 16'(period_start), 16'(exp_ps));
  endtask

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
    pwm_duty_cycle  = d;
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      tick_check();
      n++;
    end while (period_start !== 1'b1 && n < int'(PER) + 8);
    chk("ps_timeout", 16'(period_start), 16'h1);
  endtask

  // Called right after period_start is seen; counts full-high samples over one period.
  task automatic run_period(input int change_at, input logic [7:0] new_duty,
                            output int highs, output logic ps_end);
    highs = 0;
    for (int j = 1; j <= int'(PER); j++) begin
      tick_check();
      if (out === 16'hFFFF) highs++;
      if (j == change_at) pwm_duty_cycle = new_duty;
    end
    ps_end = period_start;
  endtask

  initial begin
    int n;
    int highs;
    logic pe;

    // Reset held with every input at 0xFF
    for (int i = 0; i < 4; i++) tick_check();
    chk("reset_out", out, 16'h0000);
    chk("reset_ps", 16'(period_start), 16'h0);
    rst = 1'b0;
    tick_check();
    chk("post_release_out", out, 16'h0000);
    chk("post_release_ps", 16'(period_start), 16'h0);

    // Static enables
    set_in(16'h00FF, 16'h0000, 8'h00);
    tick_check();
    chk("static_on", out, 16'h00FF);
    set_in(16'h0000, 16'h0000, 8'h00);
    tick_check();
    chk("static_off", out, 16'h0000);

    // 50 % duty on every channel
    set_in(16'hFFFF, 16'hFFFF, 8'h80);
    wait_ps(n);
    for (int k = 0; k < 2; k++) begin
      run_period(0, 8'h80, highs, pe);
      chk("duty80_highs", 16'(highs), 16'(128 * P));
      chk("duty80_gap", 16'(pe), 16'h1);
    end

    // Duty extremes
    pwm_duty_cycle = 8'h00;
    wait_ps(n);
    for (int k = 0; k < 2; k++) begin
      run_period(0, 8'h00, highs, pe);
      chk("duty00_highs", 16'(highs), 16'h0);
    end
    pwm_duty_cycle = 8'hFF;
    wait_ps(n);
    for (int k = 0; k < 2; k++) begin
      run_period(0, 8'hFF, highs, pe);
      chk("dutyFF_highs", 16'(highs), 16'(PER));
    end

    // Shadowing: change 0x40 -> 0xC0 at pwm_cnt 0x10
    pwm_duty_cycle = 8'h40;
    wait_ps(n);
    run_period(16 * P, 8'hC0, highs, pe);
    chk("shadow_cur_highs", 16'(highs), 16'(64 * P));
    chk("shadow_gap", 16'(pe), 16'h1);
    run_period(0, 8'hC0, highs, pe);
    chk("shadow_next_highs", 16'(highs), 16'(192 * P));

    // Mixed enables and mid-period reset
    set_in(16'hF0F0, 16'h3333, 8'h20);
    wait_ps(n);
    for (int i = 0; i < 3; i++) tick_check();
    chk("mixed_pwm_high", out, 16'hF0F0);
    for (int i = 0; i < 48 * P; i++) tick_check();
    chk("mixed_pwm_low", out, 16'hC0C0);
    #2 rst = 1'b1;
    #1 chk("async_reset_out", out, 16'h0000);
    chk("async_reset_ps", 16'(period_start), 16'h0);
    tick_check();
    tick_check();
    rst = 1'b0;
    tick_check();
    chk("after_reset_shadow0", out, 16'hC0C0);
    wait_ps(n);
    chk("first_boundary_after_reset", 16'(n + 1), 16'(PER));

    // Random enables and duty, changed at arbitrary points in the period
    for (int r = 0; r < 6; r++) begin
      set_in(16'($urandom), 16'($urandom), 8'($urandom));
      n = int'($urandom_range(100, 2500));
      for (int i = 0; i < n; i++) tick_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
